alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_pkg.sv | 28 ++
 rtl/btn_edge.sv | 26 ++
 rtl/alu_operand_sequencer.sv | 114 +++++++++++
 tb/tb_alu_operand_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the switch-driven ALU front end.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_MOD = 4'b1001;
    localparam logic [3:0] OP_MAX = OP_MOD;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } seq_state_t;

    function automatic logic is_div_op(input logic [3:0] opc);
        return (opc == OP_DIV) || (opc == OP_MOD);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// One-cycle pulse on a low-to-high transition of a synchronous button level.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic prev;
    logic armed;

    // armed stays low until the button has been seen released, so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= ~in;
        end else begin
            prev <= in;
            if (!in)
                armed <= 1'b1;
        end
    end

    assign pulse = in & ~prev & armed;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps operands and opcode from switches into the ALU one button press at a time, then captures the result.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_in,
    input  logic [3:0]   op_in,
    input  logic         btn_load,
    output logic [N-1:0] num1,
    output logic [N-1:0] num2,
    output logic [3:0]   op,
    input  logic [N-1:0] alu_result,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic         valid,
    output logic         err,
    output logic [2:0]   state_o
);

    seq_state_t   state, state_nx;
    logic         press;
    logic [N-1:0] num1_nx, num2_nx, result_nx;
    logic [3:0]   op_nx, flags_nx;
    logic         valid_nx, err_nx;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (btn_load),
        .pulse (press)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            num1     <= '0;
            num2     <= '0;
            op       <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            num1     <= num1_nx;
            num2     <= num2_nx;
            op       <= op_nx;
            result_q <= result_nx;
            flags_q  <= flags_nx;
            valid    <= valid_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD_A:  if (press) state_nx = LOAD_B;
            LOAD_B:  if (press) state_nx = LOAD_OP;
            LOAD_OP: if (press && (op_in <= OP_MAX)) state_nx = EXEC;
            EXEC:    state_nx = SHOW;
            SHOW:    if (press) state_nx = LOAD_A;
            default: state_nx = LOAD_A;
        endcase
    end

    // EXEC ignores press entirely; the ALU has had one full cycle on the registered operands
    always_comb begin
        num1_nx   = num1;
        num2_nx   = num2;
        op_nx     = op;
        result_nx = result_q;
        flags_nx  = flags_q;
        valid_nx  = valid;
        err_nx    = err;
        case (state)
            LOAD_A: if (press) begin
                num1_nx  = data_in;
                valid_nx = 1'b0;
                err_nx   = 1'b0;
            end
            LOAD_B: if (press) num2_nx = data_in;
            LOAD_OP: if (press) begin
                if (op_in <= OP_MAX)
                    op_nx = op_in;
                else
                    err_nx = 1'b1;
            end
            EXEC: begin
                if (is_div_op(op) && (num2 == '0)) begin
                    result_nx = '0;
                    flags_nx  = 4'b1000;
                    err_nx    = 1'b1;
                    valid_nx  = 1'b0;
                end else begin
                    result_nx = alu_result;
                    flags_nx  = {alu_z, alu_n, alu_v, alu_c};
                    valid_nx  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: the bench plays the ALU, expected captures go to a scoreboard checked when SHOW is entered.
module tb_alu_operand_sequencer;
    import alu_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic [3:0]   op_in;
    logic         btn_load;
    logic [N-1:0] num1, num2, result_q;
    logic [3:0]   op, flags_q;
    logic [N-1:0] alu_result;
    logic         alu_z, alu_n, alu_v, alu_c;
    logic         valid, err;
    logic [2:0]   state_o;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic       vld;
        logic       er;
        logic       chkErr;
        logic [3:0] n1;
        logic [3:0] n2;
        logic [3:0] opc;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    alu_operand_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .op_in      (op_in),
        .btn_load   (btn_load),
        .num1       (num1),
        .num2       (num2),
        .op         (op),
        .alu_result (alu_result),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .alu_v      (alu_v),
        .alu_c      (alu_c),
        .result_q   (result_q),
        .flags_q    (flags_q),
        .valid      (valid),
        .err        (err),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic [3:0] o, input int hold);
        @(negedge clk);
        data_in  = d;
        op_in    = o;
        btn_load = 1'b1;
        repeat (hold) @(negedge clk);
        btn_load = 1'b0;
    endtask

    task automatic runVector(input logic [3:0] a, input logic [3:0] b, input logic [3:0] opc,
                             input logic [3:0] aluRes, input logic [3:0] aluFlags,
                             input logic [3:0] expRes, input logic [3:0] expFlags,
                             input logic expValid, input logic expErr);
        exp_t e;
        alu_result = aluRes;
        {alu_z, alu_n, alu_v, alu_c} = aluFlags;
        applyStimulus(a, 4'h0, 1);
        checkOutput("load_a next state", state_o, LOAD_B);
        checkOutput("load_a clears valid", valid, 0);
        applyStimulus(b, 4'h0, 1);
        checkOutput("load_b next state", state_o, LOAD_OP);
        e = '{res: expRes, flags: expFlags, vld: expValid, er: expErr, chkErr: 1'b1,
              n1: a, n2: b, opc: opc};
        expQ.push_back(e);
        applyStimulus(4'h0, opc, 1);
        checkOutput("exec state", state_o, EXEC);
        checkOutput("valid low in exec", valid, 0);
        @(negedge clk);
        checkOutput("show after exec", state_o, SHOW);
    endtask

    initial begin : monitor
        logic [2:0] lastState;
        exp_t       e;
        lastState = 3'd0;
        forever begin
            @(negedge clk);
            if (state_o == SHOW && lastState != SHOW) begin
                if (expQ.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected capture: result 0x%0h, none required", result_q);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result_q", result_q, e.res);
                    checkOutput("flags_q", flags_q, e.flags);
                    checkOutput("valid", valid, e.vld);
                    if (e.chkErr) checkOutput("err", err, e.er);
                    checkOutput("num1", num1, e.n1);
                    checkOutput("num2", num2, e.n2);
                    checkOutput("op", op, e.opc);
                end
            end
            lastState = state_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        exp_t e;
        rst_n      = 1'b0;
        data_in    = '0;
        op_in      = '0;
        btn_load   = 1'b0;
        alu_result = '0;
        {alu_z, alu_n, alu_v, alu_c} = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset state", state_o, LOAD_A);
        checkOutput("reset outputs", {num1, num2, op, result_q, flags_q, valid, err}, 0);

        runVector(4'd3, 4'd5, OP_ADD, 4'd8, 4'b0000, 4'd8, 4'b0000, 1'b1, 1'b0);

        applyStimulus(4'd9, 4'h0, 1);
        checkOutput("show press to load_a", state_o, LOAD_A);
        checkOutput("show press captures nothing", num1, 4'd3);
        checkOutput("show press keeps result", result_q, 4'd8);

        runVector(4'd7, 4'd8, OP_ADD, 4'd15, 4'b0110, 4'd15, 4'b0110, 1'b1, 1'b0);
        applyStimulus(4'hF, 4'h0, 1);

        runVector(4'd12, 4'd0, OP_DIV, 4'hA, 4'b0101, 4'd0, 4'b1000, 1'b0, 1'b1);
        applyStimulus(4'hF, 4'h0, 1);
        checkOutput("div0 back to load_a", state_o, LOAD_A);
        checkOutput("load_a keeps num1", num1, 4'd12);

        // bad opcode is rejected without touching op, then a good one proceeds
        alu_result = 4'd2;
        {alu_z, alu_n, alu_v, alu_c} = 4'b0000;
        applyStimulus(4'd6, 4'h0, 1);
        applyStimulus(4'd2, 4'h0, 1);
        checkOutput("err cleared before op", err, 0);
        applyStimulus(4'h0, 4'b1101, 1);
        checkOutput("bad op err", err, 1);
        checkOutput("bad op stays load_op", state_o, LOAD_OP);
        checkOutput("bad op keeps op", op, OP_DIV);
        e = '{res: 4'd2, flags: 4'b0000, vld: 1'b1, er: 1'b0, chkErr: 1'b0,
              n1: 4'd6, n2: 4'd2, opc: OP_AND};
        expQ.push_back(e);
        applyStimulus(4'h0, OP_AND, 4);
        checkOutput("held press through exec stays show", state_o, SHOW);

        applyStimulus(4'h0, 4'h0, 1);
        checkOutput("back to load_a", state_o, LOAD_A);
        applyStimulus(4'd4, 4'h0, 20);
        checkOutput("held 20 cycles one advance", state_o, LOAD_B);
        checkOutput("held press num1", num1, 4'd4);
        @(negedge clk);
        checkOutput("released stays load_b", state_o, LOAD_B);
        applyStimulus(4'd1, 4'h0, 1);
        checkOutput("to load_op", state_o, LOAD_OP);

        @(negedge clk);
        rst_n    = 1'b0;
        btn_load = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid reset state", state_o, LOAD_A);
        checkOutput("mid reset outputs", {num1, num2, op, result_q, flags_q, valid, err}, 0);
        repeat (3) @(negedge clk);
        checkOutput("held through reset no press", state_o, LOAD_A);
        btn_load = 1'b0;
        applyStimulus(4'd5, 4'h0, 1);
        checkOutput("press after release", state_o, LOAD_B);
        checkOutput("press after release num1", num1, 4'd5);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
